// File: rtl/spi_result_receiver.sv
`timescale 1ns/1ps
// SPI mode-0 slave: synchronizes mosi/slave_select/spi_clock, deserializes MSB-first bytes and
// writes them sequentially into a result memory, flagging terminator, overflow and short frames.
module spi_result_receiver #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mosi,
  input  logic                  slave_select,
  input  logic                  spi_clock,
  output logic                  mem_enable,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  byte_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  finished,
  output logic                  overflow,
  output logic                  frame_error
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]     C_BITS  = CW'(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] C_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_COMMIT, S_FULL} state_t;

  logic [SYNC_STAGES-1:0] r_ss_sync, r_sclk_sync, r_mosi_sync;
  logic                   r_ss_d, r_sclk_d;
  logic                   w_ss_s, w_sclk_s, w_mosi_s;
  logic                   w_sclk_rise, w_ss_rise, w_ss_fall;

  state_t                 r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]  r_shift, w_shift_nxt;
  logic [CW-1:0]          r_bitcnt, w_bitcnt_nxt;
  logic [ADDR_WIDTH-1:0]  r_wptr, w_wptr_nxt;
  logic [ADDR_WIDTH:0]    r_count, w_count_nxt;
  logic                   r_finished, w_finished_nxt;
  logic                   r_overflow, w_overflow_nxt;
  logic                   w_write, w_frame_error;
  logic                   w_full, w_zero;

  // Idle values on reset keep a reset mid-frame from producing a spurious edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ss_sync   <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_d      <= 1'b1;
      r_sclk_d    <= 1'b0;
    end else begin
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], slave_select};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clock};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_ss_d      <= w_ss_s;
      r_sclk_d    <= w_sclk_s;
    end
  end

  assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_ss_rise   = w_ss_s & ~r_ss_d;
  assign w_ss_fall   = ~w_ss_s & r_ss_d;
  assign w_full      = (r_count >= C_DEPTH);
  assign w_zero      = (r_shift == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
      r_finished <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_wptr     <= w_wptr_nxt;
      r_count    <= w_count_nxt;
      r_finished <= w_finished_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bitcnt_nxt   = r_bitcnt;
    w_wptr_nxt     = r_wptr;
    w_count_nxt    = r_count;
    w_finished_nxt = r_finished;
    w_overflow_nxt = r_overflow;
    w_write        = 1'b0;
    w_frame_error  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss_fall) begin
          w_shift_nxt  = '0;
          w_bitcnt_nxt = '0;
          w_state_nxt  = S_RECV;
        end
      end
      S_RECV, S_FULL: begin
        if (r_bitcnt == C_BITS) begin
          w_bitcnt_nxt = '0;
          if (r_state == S_RECV) begin
            w_state_nxt = S_COMMIT;
          end else if (w_zero) begin
            w_finished_nxt = 1'b1;
            w_wptr_nxt     = '0;
            w_count_nxt    = '0;
            w_state_nxt    = w_ss_s ? S_IDLE : S_RECV;
          end else begin
            w_overflow_nxt = 1'b1;
          end
        end else if (w_ss_rise) begin
          // A frame edge beats a simultaneous clock edge; partial bytes are discarded.
          w_frame_error = (r_bitcnt != '0);
          w_bitcnt_nxt  = '0;
          if (r_state == S_RECV) w_state_nxt = S_IDLE;
        end else if (w_ss_fall) begin
          w_shift_nxt  = '0;
          w_bitcnt_nxt = '0;
        end else if (w_sclk_rise && !w_ss_s) begin
          w_shift_nxt  = {r_shift[DATA_WIDTH-2:0], w_mosi_s};
          w_bitcnt_nxt = r_bitcnt + CW'(1);
        end
      end
      S_COMMIT: begin
        w_state_nxt = w_ss_s ? S_IDLE : S_RECV;
        if (!w_full) begin
          w_write     = 1'b1;
          w_wptr_nxt  = r_wptr + ADDR_WIDTH'(1);
          w_count_nxt = r_count + (ADDR_WIDTH+1)'(1);
        end else begin
          w_overflow_nxt = 1'b1;
          if (!w_zero) w_state_nxt = S_FULL;
        end
        // The terminator is stored at the old pointer, then the block restarts at zero.
        if (w_zero) begin
          w_finished_nxt = 1'b1;
          w_wptr_nxt     = '0;
          w_count_nxt    = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign mem_enable       = w_write;
  assign mem_write_enable = w_write;
  assign byte_valid       = w_write;
  assign mem_address      = r_wptr;
  assign mem_data         = w_write ? r_shift : '0;
  assign count            = r_count;
  assign finished         = r_finished;
  assign overflow         = r_overflow;
  assign frame_error      = w_frame_error;

endmodule

// File: tb/tb_spi_result_receiver.sv
`timescale 1ns/1ps
// Directed bench for spi_result_receiver: drives SPI frames and checks memory writes and flags.
module tb_spi_result_receiver;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mosi = 1'b0;
  logic       slave_select = 1'b1;
  logic       spi_clock = 1'b0;
  logic       mem_enable, mem_write_enable, byte_valid, finished, overflow, frame_error;
  logic [4:0] mem_address;
  logic [7:0] mem_data;
  logic [5:0] count;

  int total = 0;
  int bad = 0;
  logic [4:0] wr_addr[$];
  logic [7:0] wr_data[$];
  int fe_cnt = 0;
  int strobe_bad = 0;

  always #5 clock = ~clock;

  spi_result_receiver #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .mosi(mosi), .slave_select(slave_select),
    .spi_clock(spi_clock), .mem_enable(mem_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_data(mem_data), .byte_valid(byte_valid),
    .count(count), .finished(finished), .overflow(overflow), .frame_error(frame_error));

  always @(negedge clock) begin
    if (!reset) begin
      if (byte_valid) begin
        wr_addr.push_back(mem_address);
        wr_data.push_back(mem_data);
      end
      if (mem_enable !== byte_valid || mem_write_enable !== byte_valid) strobe_bad++;
      if (frame_error) fe_cnt++;
    end
  end

  task automatic do_reset();
    reset = 1'b1; slave_select = 1'b1; spi_clock = 1'b0; mosi = 1'b0;
    repeat (3) @(posedge clock);
    reset = 1'b0;
    wr_addr.delete(); wr_data.delete(); fe_cnt = 0; strobe_bad = 0;
    repeat (4) @(posedge clock);
  endtask

  task automatic spi_bit(input logic b, input int half);
    mosi = b;
    repeat (half) @(posedge clock);
    spi_clock = 1'b1;
    repeat (half) @(posedge clock);
    spi_clock = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, input int half);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], half);
  endtask

  task automatic ss_low();
    slave_select = 1'b0;
    repeat (8) @(posedge clock);
  endtask

  task automatic ss_high();
    repeat (8) @(posedge clock);
    slave_select = 1'b1;
    repeat (12) @(posedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    total++;
    if ({mem_enable, mem_write_enable, byte_valid, finished, overflow, frame_error} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=000000",
        {mem_enable, mem_write_enable, byte_valid, finished, overflow, frame_error});
    end
    total++;
    if (mem_address !== 5'd0 || mem_data !== 8'd0 || count !== 6'd0) begin
      bad++; $display("FAIL reset_buses addr=%0d data=%h count=%0d want 0", mem_address, mem_data, count);
    end
  endtask

  task automatic test_single_slow();
    do_reset();
    ss_low();
    spi_byte(8'h3C, 313);
    ss_high();
    total++;
    if (wr_addr.size() !== 1) begin
      bad++; $display("FAIL single_writes got=%0d want=1", wr_addr.size());
    end else begin
      total++;
      if (wr_addr[0] !== 5'd0 || wr_data[0] !== 8'h3C) begin
        bad++; $display("FAIL single_data addr=%0d data=%h want addr=0 data=3c", wr_addr[0], wr_data[0]);
      end
    end
    total++;
    if (count !== 6'd1 || finished !== 1'b0) begin
      bad++; $display("FAIL single_count count=%0d fin=%b want count=1 fin=0", count, finished);
    end
    total++;
    if (strobe_bad !== 0) begin
      bad++; $display("FAIL single_strobes got=%0d want=0", strobe_bad);
    end
  endtask

  task automatic test_back_to_back_terminator();
    logic [7:0] exp[3];
    exp[0] = 8'h12; exp[1] = 8'h34; exp[2] = 8'h00;
    do_reset();
    ss_low();
    for (int i = 0; i < 3; i++) spi_byte(exp[i], 8);
    ss_high();
    total++;
    if (wr_addr.size() !== 3) begin
      bad++; $display("FAIL term_writes got=%0d want=3", wr_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wr_addr[i] !== 5'(i) || wr_data[i] !== exp[i]) begin
          bad++; $display("FAIL term_write%0d addr=%0d data=%h want addr=%0d data=%h",
            i, wr_addr[i], wr_data[i], i, exp[i]);
        end
      end
    end
    total++;
    if (finished !== 1'b1 || count !== 6'd0 || mem_address !== 5'd0) begin
      bad++; $display("FAIL term_state fin=%b count=%0d wptr=%0d want fin=1 count=0 wptr=0",
        finished, count, mem_address);
    end
  endtask

  task automatic test_frame_error();
    do_reset();
    ss_low();
    for (int i = 0; i < 5; i++) spi_bit(i[0], 8);
    ss_high();
    total++;
    if (fe_cnt !== 1 || wr_addr.size() !== 0) begin
      bad++; $display("FAIL short_frame fe=%0d writes=%0d want fe=1 writes=0", fe_cnt, wr_addr.size());
    end
    ss_low();
    spi_byte(8'hA5, 8);
    ss_high();
    total++;
    if (wr_addr.size() !== 1 || wr_data[0] !== 8'hA5 || wr_addr[0] !== 5'd0 || count !== 6'd1) begin
      bad++; $display("FAIL after_short writes=%0d count=%0d want one a5 at 0, count=1",
        wr_addr.size(), count);
    end
    total++;
    if (fe_cnt !== 1) begin
      bad++; $display("FAIL fe_pulses got=%0d want=1", fe_cnt);
    end
  endtask

  task automatic test_overflow();
    int errs;
    do_reset();
    ss_low();
    for (int i = 0; i < 32; i++) spi_byte(8'(i + 1), 8);
    repeat (12) @(posedge clock);
    total++;
    if (count !== 6'd32 || overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_at32 count=%0d ovf=%b want count=32 ovf=0", count, overflow);
    end
    spi_byte(8'h77, 8);
    repeat (12) @(posedge clock);
    total++;
    if (overflow !== 1'b1 || wr_addr.size() !== 32 || count !== 6'd32) begin
      bad++; $display("FAIL ovf_at33 ovf=%b writes=%0d count=%0d want ovf=1 writes=32 count=32",
        overflow, wr_addr.size(), count);
    end
    errs = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] !== 5'(i) || wr_data[i] !== 8'(i + 1)) errs++;
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL ovf_contents bad_entries=%0d want=0", errs);
    end
    spi_byte(8'h00, 8);
    ss_high();
    total++;
    if (finished !== 1'b1 || count !== 6'd0 || wr_addr.size() !== 32 || overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_term fin=%b count=%0d writes=%0d ovf=%b want 1/0/32/1",
        finished, count, wr_addr.size(), overflow);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    ss_low();
    for (int i = 0; i < 4; i++) spi_bit(1'b1, 8);
    reset = 1'b1; slave_select = 1'b1; spi_clock = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    total++;
    if (count !== 6'd0 || byte_valid !== 1'b0 || wr_addr.size() !== 0) begin
      bad++; $display("FAIL mid_reset count=%0d bv=%b writes=%0d want 0", count, byte_valid, wr_addr.size());
    end
    reset = 1'b0;
    repeat (6) @(posedge clock);
    ss_low();
    spi_byte(8'h81, 8);
    ss_high();
    total++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== 5'd0 || wr_data[0] !== 8'h81 || fe_cnt !== 0) begin
      bad++; $display("FAIL post_reset writes=%0d fe=%0d want one 81 at 0 and fe=0", wr_addr.size(), fe_cnt);
    end
  endtask

  task automatic test_idle_sclk();
    do_reset();
    mosi = 1'b1;
    for (int i = 0; i < 16; i++) begin
      spi_clock = ~spi_clock;
      repeat (8) @(posedge clock);
    end
    repeat (8) @(posedge clock);
    @(negedge clock);
    total++;
    if (wr_addr.size() !== 0 || count !== 6'd0 || fe_cnt !== 0) begin
      bad++; $display("FAIL idle_sclk writes=%0d count=%0d fe=%0d want 0", wr_addr.size(), count, fe_cnt);
    end
    total++;
    if ({finished, overflow, byte_valid, mem_enable} !== 4'b0 || mem_data !== 8'd0 || mem_address !== 5'd0) begin
      bad++; $display("FAIL idle_outputs fin=%b ovf=%b bv=%b en=%b data=%h addr=%0d want 0",
        finished, overflow, byte_valid, mem_enable, mem_data, mem_address);
    end
  endtask

  initial begin
    test_reset();
    test_single_slow();
    test_back_to_back_terminator();
    test_frame_error();
    test_overflow();
    test_reset_mid_frame();
    test_idle_sclk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
